// File: rtl/audio_mixer.sv
// Multi-channel audio mixer: per-frame gain ramping, one shared multiply-accumulate
// stepping through the channels, then an arithmetic shift and saturation to DATA_W.
module audio_mixer #(
    parameter int DATA_W     = 16,
    parameter int CHANNELS   = 4,
    parameter int GAIN_W     = 4,
    parameter int GAIN_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_req,
    input  logic [CHANNELS*DATA_W-1:0] samples_in,
    input  logic [CHANNELS*GAIN_W-1:0] gain_target,
    input  logic                       mute,
    output logic [DATA_W-1:0]          mix_out,
    output logic                       mix_valid,
    output logic                       clip,
    output logic                       busy,
    output logic                       overrun
);
    localparam int CNT_W  = $clog2(CHANNELS);
    localparam int IDX_W  = (CHANNELS > 1) ? CNT_W : 1;
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + CNT_W;

    typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

    state_t                           state, state_next;
    logic [CHANNELS-1:0][DATA_W-1:0]  bank;
    logic [CHANNELS-1:0][GAIN_W-1:0]  cur_gain;
    logic signed [ACC_W-1:0]          acc;
    logic [IDX_W-1:0]                 idx;
    logic                             last;
    logic                             accept;
    logic signed [PROD_W-1:0]         smp_ext, gain_ext, prod;
    logic signed [ACC_W-1:0]          shifted;
    logic                             in_range;
    logic [DATA_W-1:0]                sat_val;

    assign last   = (idx == IDX_W'(CHANNELS - 1));
    assign accept = (state == IDLE) && sample_req;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_req) state_next = MAC;
            MAC:     if (last) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gain is zero-extended by one bit so the product stays a signed multiply.
    always_comb begin
        smp_ext  = PROD_W'($signed(bank[idx]));
        gain_ext = PROD_W'({1'b0, cur_gain[idx]});
        prod     = smp_ext * gain_ext;
    end

    // In range when every bit above the output sign bit matches it.
    always_comb begin
        shifted  = acc >>> GAIN_SHIFT;
        in_range = (&shifted[ACC_W-1:DATA_W-1]) | ~(|shifted[ACC_W-1:DATA_W-1]);
        sat_val  = in_range ? shifted[DATA_W-1:0]
                            : {shifted[ACC_W-1], {(DATA_W-1){~shifted[ACC_W-1]}}};
    end

    always_ff @(posedge clk) begin
        if (accept) bank <= samples_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_gain <= '0;
        end else if (accept) begin
            for (int k = 0; k < CHANNELS; k++) begin
                logic [GAIN_W-1:0] eff;
                eff = mute ? '0 : gain_target[k*GAIN_W +: GAIN_W];
                if (cur_gain[k] < eff)      cur_gain[k] <= cur_gain[k] + GAIN_W'(1);
                else if (cur_gain[k] > eff) cur_gain[k] <= cur_gain[k] - GAIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            clip      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            overrun   <= sample_req && (state != IDLE);
            mix_valid <= 1'b0;
            clip      <= 1'b0;
            case (state)
                IDLE: if (sample_req) begin
                    acc <= '0;
                    idx <= '0;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + IDX_W'(1);
                end
                SAT: begin
                    mix_out   <= sat_val;
                    mix_valid <= 1'b1;
                    clip      <= ~in_range;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/audio_mixer.md
# audio_mixer

Parametrised multi-channel audio mixer that sits between the audio sources (tone generator, loopback, effects output, recorded data) and the codec playback path. It replaces a fixed two-source select-and-scale with CHANNELS signed inputs, each with its own gain. Gains ramp one step per frame toward their targets to avoid zipper noise and clicks. Per-channel products are summed with a single time-multiplexed multiply-accumulate, then shifted and saturated to DATA_W. One mixed sample is produced per codec sample request.

## Interface
Parameters:
- DATA_W, 16, sample width; signed two's complement on inputs and output.
- CHANNELS, 4, number of input channels; minimum 1.
- GAIN_W, 4, per-channel gain width; gain is unsigned.
- GAIN_SHIFT, 2, arithmetic right shift applied to the sum; unity gain = 2^GAIN_SHIFT.

Ports:
- clk  in  1  single clock (audio clock domain).
- reset  in  1  synchronous, active-high.
- sample_req  in  1  one-cycle pulse requesting a new mixed sample (codec sample_req).
- samples_in  in  CHANNELS*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- gain_target  in  CHANNELS*GAIN_W  channel k occupies bits [k*GAIN_W +: GAIN_W].
- mute  in  1  level; while high, every channel's effective target is 0.
- mix_out  out  DATA_W  mixed, saturated sample; holds its value between frames.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- clip  out  1  valid only with mix_valid; 1 if this frame saturated.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  one-cycle pulse when sample_req arrives while busy.

## Operation
- **State machine:** IDLE -> MAC -> SAT -> IDLE.
- **IDLE, sample_req = 1:**
  - Latch samples_in into an internal sample bank.
  - Update each cur_gain[k] by one step toward its effective target (0 if mute, else gain_target[k]): +1 if below, -1 if above, unchanged if equal.
  - Clear the accumulator, set index to 0, go to MAC.
- **MAC:**
  - One channel per cycle: acc += sample[idx] * cur_gain[idx], where cur_gain is the already-updated value.
  - The product is signed × unsigned, with the gain zero-extended by 1 bit.
  - After index CHANNELS-1, go to SAT.
- **Accumulator width:** ACC_W = DATA_W + GAIN_W + 1 + clog2(CHANNELS). No internal overflow is possible.
- **SAT:**
  - s = acc >>> GAIN_SHIFT (arithmetic shift; truncates toward minus infinity).
  - If s > 2^(DATA_W-1)-1, output the maximum positive value. If s < -2^(DATA_W-1), output the minimum negative value. Otherwise output s.
  - Register the result into mix_out, pulse mix_valid, set clip if limited, return to IDLE.
- **busy:** high in MAC and SAT.
- **sample_req outside IDLE:** ignored for the mix; pulses overrun the following cycle. No queueing, and the frame in progress is unaffected.
- **Input stability:** samples_in and gain_target are sampled only at the latch edge. Later changes do not affect the frame in progress.
- **Mute:** takes effect at the next latch edge and ramps gains down one step per frame. Releasing mute ramps them back up.
- **Reset:**
  - Output values: mix_out = 0, mix_valid = 0, clip = 0, busy = 0, overrun = 0.
  - Internal state: all cur_gain = 0, state = IDLE.
  - Reset asserted mid-frame aborts the frame: no mix_valid is produced for it, and the gain ramp restarts from 0.

## Timing
- If sample_req is high in cycle 0 while IDLE:
  - busy is high in cycles 1 .. CHANNELS+1.
  - mix_valid (with mix_out and clip) is high in cycle CHANNELS+2, i.e. cycle 6 for CHANNELS = 4.
- The earliest accepted next sample_req is in cycle CHANNELS+2. A sample_req in that same cycle as mix_valid is accepted.
- Throughput: one frame per CHANNELS+2 cycles. With the audio clock (~11.29 MHz) and 48 kHz requests there is ample margin.
- All outputs are registered; no combinational input-to-output paths.
- mix_valid, overrun and clip never extend beyond one cycle.

## Test plan
All scenarios use default parameters unless noted.
1. **Gain ramp-up:** reset, then gain_target = 4 for all channels, ch0 = 1000, others = 0, one sample_req per 20 cycles -> mix_out = 250, 500, 750, 1000, 1000, ...; clip = 0 throughout.
2. **Latency and overrun:** sample_req in cycle 0 -> busy high in cycles 1-5 and mix_valid in cycle 6. A second sample_req in cycle 3 -> overrun pulse in cycle 4, and only one mix_valid is produced.
3. **Saturation:** after ramping to gain 15, all channels = 32767 -> mix_out = 32767, clip = 1. All channels = -32768 -> mix_out = -32768, clip = 1. Channels = +8000, -8000, 0, 0 -> mix_out = 0, clip = 0.
4. **Mute ramp:** steady state of scenario 1, assert mute -> 750, 500, 250, 0, 0. Deassert mute -> 250, 500, ...
5. **Mid-frame changes:** change samples_in and gain_target in cycle 2 of a frame -> that frame's result uses the values latched in cycle 0.
6. **Reset mid-frame:** reset in cycle 3 of a frame -> no mix_valid, mix_out = 0. The next frame with ch0 = 1000 and target 4 yields 250.
